c4_board_ctrl: RTL and testbench
================================

Name: c4_board_ctrl

Overview:
- Parametrised Connect Four board store: generalises the single-column, fixed-keycode drop logic to N_COLS x N_ROWS columns.
- Adds automatic turn alternation, one-move-per-keypress edge detection, full-column rejection, board-full detection and a clear command.
- Sits between the keyboard keycode path and the piece-drawing logic. Its occupancy vectors feed the renderer and any later win checker.

Parameters:
- N_COLS, 7, number of columns (1..16)
- N_ROWS, 6, number of rows per column (1..15); row 0 is the bottom slot
- FIRST_COL_KEY, 8'h1E, HID keycode for column 0; column c uses FIRST_COL_KEY+c
- CLEAR_KEY, 8'h29, HID keycode that clears the board

Ports:
- Reset  in  1  asynchronous, active-high reset
- frame_clk  in  1  clock
- keycode  in  8  current HID keycode; 8'h00 means no key
- board_red  out  N_COLS*N_ROWS  occupancy by red; bit col*N_ROWS+row
- board_black  out  N_COLS*N_ROWS  occupancy by black; same indexing
- col_height  out  N_COLS*HW  packed per-column fill count; HW=$clog2(N_ROWS+1)
- turn  out  1  0 = red to move, 1 = black to move
- move_valid  out  1  one-cycle pulse when a piece is placed
- invalid  out  1  one-cycle pulse when a drop targets a full column
- last_col  out  4  column of the most recent placed piece
- last_row  out  4  row of the most recent placed piece
- board_full  out  1  high when every column height equals N_ROWS

Behaviour:
- Reset (async): clear all board bits, heights, turn, pulses, last_col/last_row and key_prev to 0; board_full=0.
- key_prev is a register updated with keycode every frame_clk.
- Accept event: keycode != key_prev and keycode is an action key (column key with index < N_COLS, or CLEAR_KEY).
  - Holding a key, or any other keycode, causes no action. Release and re-press is required to repeat a column.
  - A direct change from one column key to another is accepted.
- Column accept on column c, with h = height[c]:
  - h < N_ROWS: set bit c*N_ROWS+h in board_red (turn=0) or board_black (turn=1); height[c]++; turn toggles; move_valid=1 for one cycle; last_col=c, last_row=h.
  - h == N_ROWS: no board change, turn unchanged, invalid=1 for one cycle.
- Clear accept: synchronously zero the board, heights, turn and last_col/last_row. No pulse.
- All updates are registered: effects are visible after the same frame_clk edge that first samples the new keycode. Latency is 1 edge.
- Column keys with index >= N_COLS are ignored (no pulse).
- Invariants:
  - board_red & board_black == 0 at all times.
  - Within a column, occupied bits are contiguous from row 0, and their count equals col_height.
- board_full is combinational from the heights. Drops while board_full=1 produce invalid.
- move_valid and invalid are never high together. Both are 0 in any cycle without an accept.
- Reset asserted mid-game overrides everything immediately. After deassertion, the first key needs a change versus key_prev=0.

Decomposition:
- Package c4_pkg:
  - player_t enum (RED=0, BLACK=1)
  - HID keycode constants (KEY_1..KEY_7, KEY_ESC)
  - default N_COLS/N_ROWS localparams
  - function cell_idx(col,row)
- Sub-module c4_key_edge: holds key_prev and outputs a one-cycle accept strobe plus decoded col index / clear flag.

Test Plan:
- Reset, then keycode 0x1E for 1 frame then 0x00 -> board_red[0]=1, col_height[0]=1, turn=1, move_valid pulse, last_col=0, last_row=0.
- Next 0x1E press -> board_black[1]=1, height[0]=2, turn=0. Holding 0x1F for 5 frames -> exactly one piece in col 1 (bit 6).
- Six alternating presses on col 3, then a 7th -> invalid pulse, board and turn unchanged, col_height[3]=6.
- Keycode 0x24 with N_COLS=5 -> no change, no pulse. 0x29 after several moves -> all boards 0, turn=0.
- Fill all 42 cells -> board_full=1 after the 42nd move; a further press -> invalid.
- Assert Reset between frame_clk edges mid-game -> all outputs 0 immediately without waiting for a clock edge.

Source files
------------

// File: rtl/c4_pkg.sv
// Shared types and constants for the Connect Four board store.
// Keycodes are USB HID usage IDs as delivered by the keyboard path.
package c4_pkg;

  typedef enum logic {
    RED   = 1'b0,
    BLACK = 1'b1
  } player_t;

  localparam logic [7:0] KEY_1   = 8'h1E;
  localparam logic [7:0] KEY_2   = 8'h1F;
  localparam logic [7:0] KEY_3   = 8'h20;
  localparam logic [7:0] KEY_4   = 8'h21;
  localparam logic [7:0] KEY_5   = 8'h22;
  localparam logic [7:0] KEY_6   = 8'h23;
  localparam logic [7:0] KEY_7   = 8'h24;
  localparam logic [7:0] KEY_ESC = 8'h29;

  localparam int DEF_N_COLS = 7;
  localparam int DEF_N_ROWS = 6;

  // Flat bit position of a cell; columns are stored as contiguous row groups.
  function automatic int cell_idx(input int col, input int row, input int nRows);
    return col * nRows + row;
  endfunction

endpackage

// File: rtl/c4_key_edge.sv
// Keypress edge detector: remembers the previous keycode and strobes once
// when a new action key (column or clear) appears.
module c4_key_edge
  import c4_pkg::*;
#(
  parameter int         N_COLS        = DEF_N_COLS,
  parameter logic [7:0] FIRST_COL_KEY = KEY_1,
  parameter logic [7:0] CLEAR_KEY     = KEY_ESC,
  localparam int        CW            = (N_COLS > 1) ? $clog2(N_COLS) : 1
)(
  input  logic          Reset,
  input  logic          frame_clk,
  input  logic [7:0]    keycode,
  output logic          o_colAccept,
  output logic          o_clear,
  output logic [CW-1:0] o_col
);

  logic [7:0] r_keyPrev;
  logic [7:0] w_offset;
  logic       w_changed;
  logic       w_isCol;
  logic       w_isClear;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) r_keyPrev <= '0;
    else       r_keyPrev <= keycode;
  end

  // Clear takes priority in case a parameterisation makes the key ranges overlap.
  always_comb begin
    w_offset    = keycode - FIRST_COL_KEY;
    w_changed   = (keycode != r_keyPrev);
    w_isClear   = (keycode == CLEAR_KEY);
    w_isCol     = (keycode >= FIRST_COL_KEY) && (w_offset < 8'(N_COLS)) && !w_isClear;
    o_clear     = w_changed && w_isClear;
    o_colAccept = w_changed && w_isCol;
    o_col       = w_offset[CW-1:0];
  end

endmodule

// File: rtl/c4_board_ctrl.sv
// Connect Four board store: drops pieces into columns on keypresses,
// alternates turns, rejects full columns and supports a clear key.
module c4_board_ctrl
  import c4_pkg::*;
#(
  parameter int         N_COLS        = DEF_N_COLS,
  parameter int         N_ROWS        = DEF_N_ROWS,
  parameter logic [7:0] FIRST_COL_KEY = KEY_1,
  parameter logic [7:0] CLEAR_KEY     = KEY_ESC,
  localparam int        HW            = $clog2(N_ROWS + 1)
)(
  input  logic                     Reset,
  input  logic                     frame_clk,
  input  logic [7:0]               keycode,
  output logic [N_COLS*N_ROWS-1:0] board_red,
  output logic [N_COLS*N_ROWS-1:0] board_black,
  output logic [N_COLS*HW-1:0]     col_height,
  output logic                     turn,
  output logic                     move_valid,
  output logic                     invalid,
  output logic [3:0]               last_col,
  output logic [3:0]               last_row,
  output logic                     board_full
);

  localparam int CELLS = N_COLS * N_ROWS;
  localparam int CW    = (N_COLS > 1) ? $clog2(N_COLS) : 1;

  logic            w_colAccept;
  logic            w_clear;
  logic [CW-1:0]   w_col;
  logic [HW-1:0]   w_curHeight;
  logic            w_colFull;
  logic [CELLS-1:0] w_cellMask;
  logic            w_boardFull;

  logic [HW-1:0]   r_height [N_COLS];
  logic [CELLS-1:0] r_red;
  logic [CELLS-1:0] r_black;
  player_t         r_turn;
  logic            r_moveValid;
  logic            r_invalid;
  logic [3:0]      r_lastCol;
  logic [3:0]      r_lastRow;

  c4_key_edge #(
    .N_COLS        (N_COLS),
    .FIRST_COL_KEY (FIRST_COL_KEY),
    .CLEAR_KEY     (CLEAR_KEY)
  ) u_keyEdge (
    .Reset       (Reset),
    .frame_clk   (frame_clk),
    .keycode     (keycode),
    .o_colAccept (w_colAccept),
    .o_clear     (w_clear),
    .o_col       (w_col)
  );

  // The landing slot is the column's current height, i.e. the lowest empty row.
  always_comb begin
    w_curHeight = r_height[w_col];
    w_colFull   = (w_curHeight == HW'(N_ROWS));
    w_cellMask  = CELLS'(1) << cell_idx(int'(w_col), int'(w_curHeight), N_ROWS);
  end

  always_comb begin
    w_boardFull = 1'b1;
    for (int c = 0; c < N_COLS; c++) begin
      if (r_height[c] != HW'(N_ROWS)) w_boardFull = 1'b0;
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_red       <= '0;
      r_black     <= '0;
      r_turn      <= RED;
      r_moveValid <= 1'b0;
      r_invalid   <= 1'b0;
      r_lastCol   <= '0;
      r_lastRow   <= '0;
      for (int c = 0; c < N_COLS; c++) r_height[c] <= '0;
    end else begin
      r_moveValid <= 1'b0;
      r_invalid   <= 1'b0;
      if (w_clear) begin
        r_red     <= '0;
        r_black   <= '0;
        r_turn    <= RED;
        r_lastCol <= '0;
        r_lastRow <= '0;
        for (int c = 0; c < N_COLS; c++) r_height[c] <= '0;
      end else if (w_colAccept) begin
        if (w_colFull) begin
          r_invalid <= 1'b1;
        end else begin
          if (r_turn == RED) r_red   <= r_red | w_cellMask;
          else               r_black <= r_black | w_cellMask;
          r_height[w_col] <= w_curHeight + HW'(1);
          r_turn          <= (r_turn == RED) ? BLACK : RED;
          r_moveValid     <= 1'b1;
          r_lastCol       <= 4'(w_col);
          r_lastRow       <= 4'(w_curHeight);
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < N_COLS; c++) col_height[c*HW +: HW] = r_height[c];
  end

  assign board_red   = r_red;
  assign board_black = r_black;
  assign turn        = r_turn;
  assign move_valid  = r_moveValid;
  assign invalid     = r_invalid;
  assign last_col    = r_lastCol;
  assign last_row    = r_lastRow;
  assign board_full  = w_boardFull;

endmodule

// File: tb/tb_c4_board_ctrl.sv
// Randomised and directed bench for c4_board_ctrl against a grid-level model
// of the game (owner per cell, height per column, whose turn).
module tb_c4_board_ctrl;

  localparam int NC    = 7;
  localparam int NR    = 6;
  localparam int HW    = 3;
  localparam int CELLS = NC * NR;

  logic             Reset;
  logic             frame_clk = 1'b0;
  logic [7:0]       keycode;
  logic [CELLS-1:0] board_red;
  logic [CELLS-1:0] board_black;
  logic [NC*HW-1:0] col_height;
  logic             turn;
  logic             move_valid;
  logic             invalid;
  logic [3:0]       last_col;
  logic [3:0]       last_row;
  logic             board_full;

  c4_board_ctrl dut (
    .Reset       (Reset),
    .frame_clk   (frame_clk),
    .keycode     (keycode),
    .board_red   (board_red),
    .board_black (board_black),
    .col_height  (col_height),
    .turn        (turn),
    .move_valid  (move_valid),
    .invalid     (invalid),
    .last_col    (last_col),
    .last_row    (last_row),
    .board_full  (board_full)
  );

  always #5 frame_clk = ~frame_clk;

  int errorCount = 0;
  int checkCount = 0;

  // Model: ownerM is -1 empty, 0 red, 1 black.
  int         ownerM [NC][NR];
  int         heightM [NC];
  int         turnM;
  int         moveM;
  int         invM;
  int         lastColM;
  int         lastRowM;
  logic [7:0] prevM;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  function automatic void modelReset();
    for (int c = 0; c < NC; c++) begin
      heightM[c] = 0;
      for (int r = 0; r < NR; r++) ownerM[c][r] = -1;
    end
    turnM = 0; moveM = 0; invM = 0; lastColM = 0; lastRowM = 0; prevM = 8'h00;
  endfunction

  function automatic void modelStep(input logic [7:0] k);
    int c;
    moveM = 0;
    invM  = 0;
    if (k != prevM) begin
      if (k == 8'h29) begin
        for (int cc = 0; cc < NC; cc++) begin
          heightM[cc] = 0;
          for (int r = 0; r < NR; r++) ownerM[cc][r] = -1;
        end
        turnM = 0; lastColM = 0; lastRowM = 0;
      end else if (int'(k) >= 'h1E && int'(k) < 'h1E + NC) begin
        c = int'(k) - 'h1E;
        if (heightM[c] < NR) begin
          ownerM[c][heightM[c]] = turnM;
          lastColM = c;
          lastRowM = heightM[c];
          heightM[c] = heightM[c] + 1;
          turnM = 1 - turnM;
          moveM = 1;
        end else begin
          invM = 1;
        end
      end
    end
    prevM = k;
  endfunction

  task automatic compareAll(input string ctx);
    logic [CELLS-1:0] expRed;
    logic [CELLS-1:0] expBlack;
    logic [NC*HW-1:0] expHeight;
    int               full;
    expRed = '0; expBlack = '0; expHeight = '0; full = 1;
    for (int c = 0; c < NC; c++) begin
      for (int r = 0; r < NR; r++) begin
        if (ownerM[c][r] == 0) expRed[c*NR + r] = 1'b1;
        if (ownerM[c][r] == 1) expBlack[c*NR + r] = 1'b1;
      end
      expHeight[c*HW +: HW] = HW'(heightM[c]);
      if (heightM[c] != NR) full = 0;
    end
    checkOutput({ctx, ".red"},        64'(board_red),   64'(expRed));
    checkOutput({ctx, ".black"},      64'(board_black), 64'(expBlack));
    checkOutput({ctx, ".overlap"},    64'(board_red & board_black), 64'd0);
    checkOutput({ctx, ".height"},     64'(col_height),  64'(expHeight));
    checkOutput({ctx, ".turn"},       64'(turn),        64'(turnM));
    checkOutput({ctx, ".move_valid"}, 64'(move_valid),  64'(moveM));
    checkOutput({ctx, ".invalid"},    64'(invalid),     64'(invM));
    checkOutput({ctx, ".last_col"},   64'(last_col),    64'(lastColM));
    checkOutput({ctx, ".last_row"},   64'(last_row),    64'(lastRowM));
    checkOutput({ctx, ".board_full"}, 64'(board_full),  64'(full));
  endtask

  task automatic applyStimulus(input logic [7:0] k, input string ctx);
    keycode = k;
    @(posedge frame_clk);
    modelStep(k);
    #1;
    compareAll(ctx);
  endtask

  task automatic press(input logic [7:0] k, input string ctx);
    applyStimulus(k, ctx);
    applyStimulus(8'h00, {ctx, ".rel"});
  endtask

  initial begin
    logic [7:0] k;
    int         sel;
    Reset   = 1'b1;
    keycode = 8'h00;
    modelReset();
    #3;
    compareAll("reset");
    #9;
    Reset = 1'b0;

    press(8'h1E, "firstRed");
    press(8'h1E, "firstBlack");
    for (int i = 0; i < 5; i++) applyStimulus(8'h1F, "holdCol1");
    applyStimulus(8'h00, "holdRel");
    checkOutput("col1Bit6", 64'(board_red[6] | board_black[6]), 64'd1);
    checkOutput("col1Bit7", 64'(board_red[7] | board_black[7]), 64'd0);

    for (int i = 0; i < 7; i++) press(8'h21, "fillCol3");
    checkOutput("col3Height", 64'(col_height[3*HW +: HW]), 64'd6);

    applyStimulus(8'h25, "ignoredKey");
    applyStimulus(8'h1E, "directChangeA");
    applyStimulus(8'h1F, "directChangeB");
    applyStimulus(8'h42, "otherKey");
    press(8'h29, "clear");

    for (int c = 0; c < NC; c++)
      for (int r = 0; r < NR; r++) press(8'(8'h1E + c), "fillAll");
    checkOutput("boardFull", 64'(board_full), 64'd1);
    applyStimulus(8'h20, "dropWhenFull");
    checkOutput("fullInvalid", 64'(invalid), 64'd1);
    press(8'h29, "clearFull");

    for (int i = 0; i < 600; i++) begin
      sel = int'($urandom_range(0, 99));
      if (sel < 40)      k = 8'h00;
      else if (sel < 88) k = 8'(8'h1E + $urandom_range(0, NC - 1));
      else if (sel < 91) k = 8'h29;
      else if (sel < 96) k = 8'(8'h25 + $urandom_range(0, 3));
      else               k = 8'($urandom_range(0, 255));
      applyStimulus(k, "random");
    end

    press(8'h22, "preReset");
    applyStimulus(8'h23, "preReset2");
    #2;
    Reset = 1'b1;
    #1;
    modelReset();
    compareAll("asyncReset");
    keycode = 8'h1E;
    @(posedge frame_clk);
    #1;
    compareAll("heldReset");
    #2;
    Reset = 1'b0;
    applyStimulus(8'h1E, "afterReset");
    applyStimulus(8'h1E, "afterResetHold");

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
